order_issue_scheduler: RTL and testbench

Arbitrates outbound order requests from four per-stock strategy lanes (AAPL=0, AMZN=1, GOOGL=2, MSFT=3) and sequences them one at a time into the ITCH reverse parser. The block honours the order book's busy flag and a programmable minimum inter-order gap. It stamps each issued order with a unique order number and a free-running timestamp, so the parser no longer needs hardcoded values for these fields. It sits between the quote-price/quantity-estimation stage and the reverse parser.

---
 rtl/order_issue_scheduler_if.sv | 37 +++
 rtl/order_issue_scheduler.sv | 97 +++++++++
 tb/tb_order_issue_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_issue_scheduler_if.sv
// Order request/issue bundle between the strategy lanes, the scheduler and the reverse parser.
// master = requester/consumer side, slave = scheduler side.
interface order_issue_scheduler_if #(
  parameter int REG_WIDTH = 32
);
  logic                     i_enable;
  logic                     i_book_is_busy;
  logic [3:0]               i_req;
  logic [3:0]               i_req_trade_type;
  logic [4*REG_WIDTH-1:0]   i_req_buy_price;
  logic [4*REG_WIDTH-1:0]   i_req_sell_price;
  logic [4*16-1:0]          i_req_quantity;
  logic [3:0]               o_grant;
  logic                     o_data_valid;
  logic [1:0]               o_stock_symbol;
  logic                     o_trade_type;
  logic [REG_WIDTH-1:0]     o_buy_price;
  logic [REG_WIDTH-1:0]     o_sell_price;
  logic [15:0]              o_quantity;
  logic [REG_WIDTH-1:0]     o_order_id;
  logic [REG_WIDTH-1:0]     o_timestamp;
  logic                     o_busy;

  modport master (
    output i_enable, i_book_is_busy, i_req, i_req_trade_type,
           i_req_buy_price, i_req_sell_price, i_req_quantity,
    input  o_grant, o_data_valid, o_stock_symbol, o_trade_type, o_buy_price,
           o_sell_price, o_quantity, o_order_id, o_timestamp, o_busy
  );

  modport slave (
    input  i_enable, i_book_is_busy, i_req, i_req_trade_type,
           i_req_buy_price, i_req_sell_price, i_req_quantity,
    output o_grant, o_data_valid, o_stock_symbol, o_trade_type, o_buy_price,
           o_sell_price, o_quantity, o_order_id, o_timestamp, o_busy
  );
endinterface

// File: rtl/order_issue_scheduler.sv
// Round-robin issue of 4 lane orders, stamped with order id and timestamp; valid 1 cycle after accept.
// Accepts only in IDLE with enable and book not busy; each issue is followed by MIN_GAP idle cycles.
module order_issue_scheduler #(
  parameter int                   REG_WIDTH     = 32,
  parameter int                   MIN_GAP       = 2,
  parameter logic [REG_WIDTH-1:0] ORDER_ID_BASE = REG_WIDTH'(32'h03BA)
) (
  input logic                   i_clk,
  input logic                   i_reset,
  order_issue_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           rr_ptr;
  logic [1:0]           win;
  logic                 win_found;
  logic                 accept;
  logic [7:0]           gap_cnt;
  logic [REG_WIDTH-1:0] ts_cnt;
  logic [REG_WIDTH-1:0] next_id;

  // Search upward from rr_ptr with wrap; first requesting lane wins.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win       = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!win_found && bus.i_req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign accept = (state == IDLE) && bus.i_enable && !bus.i_book_is_busy && win_found;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MIN_GAP == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr              <= 2'd0;
      gap_cnt             <= 8'd0;
      ts_cnt              <= '0;
      next_id             <= ORDER_ID_BASE;
      bus.o_grant         <= 4'd0;
      bus.o_data_valid    <= 1'b0;
      bus.o_stock_symbol  <= 2'd0;
      bus.o_trade_type    <= 1'b0;
      bus.o_buy_price     <= '0;
      bus.o_sell_price    <= '0;
      bus.o_quantity      <= 16'd0;
      bus.o_order_id      <= '0;
      bus.o_timestamp     <= '0;
    end else begin
      ts_cnt           <= ts_cnt + 1'b1;
      bus.o_data_valid <= accept;
      bus.o_grant      <= accept ? 4'(4'b0001 << win) : 4'd0;
      if (accept) begin
        bus.o_stock_symbol <= win;
        bus.o_trade_type   <= bus.i_req_trade_type[win];
        bus.o_buy_price    <= bus.i_req_buy_price[int'(win)*REG_WIDTH +: REG_WIDTH];
        bus.o_sell_price   <= bus.i_req_sell_price[int'(win)*REG_WIDTH +: REG_WIDTH];
        bus.o_quantity     <= bus.i_req_quantity[int'(win)*16 +: 16];
        bus.o_order_id     <= next_id;
        bus.o_timestamp    <= ts_cnt;
        next_id            <= next_id + 1'b1;
        rr_ptr             <= win + 2'd1;
      end
      // gap_cnt is loaded during ISSUE so GAP spans exactly MIN_GAP cycles.
      if (state == ISSUE)
        gap_cnt <= (MIN_GAP == 0) ? 8'd0 : 8'(MIN_GAP - 1);
      else if (state == GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;
    end
  end

  assign bus.o_busy = (state != IDLE);

endmodule

// File: tb/tb_order_issue_scheduler.sv
// Scoreboard bench for order_issue_scheduler: expected issues queued at stimulus, checked at o_data_valid.
module tb_order_issue_scheduler;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  order_issue_scheduler_if #(.REG_WIDTH(W)) bus ();
  order_issue_scheduler_if #(.REG_WIDTH(W)) bus_w ();

  order_issue_scheduler #(.REG_WIDTH(W), .MIN_GAP(2), .ORDER_ID_BASE(32'h0000_03BA)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus.slave)
  );
  order_issue_scheduler #(.REG_WIDTH(W), .MIN_GAP(2), .ORDER_ID_BASE(32'hFFFF_FFFF)) dut_w (
    .i_clk(clk), .i_reset(rst), .bus(bus_w.slave)
  );

  typedef struct packed {
    logic [3:0]   grant;
    logic [1:0]   sym;
    logic         tt;
    logic [W-1:0] buy;
    logic [W-1:0] sell;
    logic [15:0]  qty;
    logic [W-1:0] id;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  m_rr;
  logic [W-1:0] m_id;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t observe();
    exp_t o;
    o.grant = bus.o_grant;
    o.sym   = bus.o_stock_symbol;
    o.tt    = bus.o_trade_type;
    o.buy   = bus.o_buy_price;
    o.sell  = bus.o_sell_price;
    o.qty   = bus.o_quantity;
    o.id    = bus.o_order_id;
    return o;
  endfunction

  task automatic set_lane(input int n, input logic tt, input logic [W-1:0] buy,
                          input logic [W-1:0] sell, input logic [15:0] qty);
    bus.i_req_trade_type[n]         = tt;
    bus.i_req_buy_price[n*W +: W]   = buy;
    bus.i_req_sell_price[n*W +: W]  = sell;
    bus.i_req_quantity[n*16 +: 16]  = qty;
  endtask

  // Reference arbitration: round-robin from m_rr upward with wrap.
  task automatic push_exp(input logic [3:0] req);
    exp_t e;
    logic [1:0] w;
    logic [1:0] idx;
    bit f;
    f = 0;
    w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(int'(m_rr) + i);
      if (!f && req[idx]) begin
        f = 1;
        w = idx;
      end
    end
    e.grant = 4'(4'b0001 << w);
    e.sym   = w;
    e.tt    = bus.i_req_trade_type[w];
    e.buy   = bus.i_req_buy_price[int'(w)*W +: W];
    e.sell  = bus.i_req_sell_price[int'(w)*W +: W];
    e.qty   = bus.i_req_quantity[int'(w)*16 +: 16];
    e.id    = m_id;
    sb.push_back(e);
    m_rr = w + 2'd1;
    m_id = m_id + 1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_data_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s idle_timeout busy=%b want=0", name, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    exp_t e, o;
    bit ok;
    @(negedge clk);
    rst = 1'b1;
    bus.i_req = 4'b1111;
    repeat (3) @(negedge clk);
    total++;
    if (observe() !== '0 || bus.o_data_valid !== 1'b0 || bus.o_timestamp !== '0 ||
        bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%h v=%b ts=%h busy=%b want=all zero",
               observe(), bus.o_data_valid, bus.o_timestamp, bus.o_busy);
    end
    rst  = 1'b0;
    m_rr = 2'd0;
    m_id = 32'h03BA;
    push_exp(4'b1111);
    wait_valid(ok);
    bus.i_req = 4'b0000;
    total++;
    e = sb.pop_front();
    o = observe();
    if (!ok || o !== e) begin
      bad++;
      $display("FAIL reset_first_issue valid=%b got=%h want=%h", ok, o, e);
    end
    wait_idle("reset");
  endtask

  task automatic test_single();
    exp_t e, o;
    set_lane(2, 1'b1, 32'h60, 32'h64, 16'd10);
    @(negedge clk);
    bus.i_req = 4'b0100;
    push_exp(4'b0100);
    @(negedge clk);
    total++;
    if (bus.o_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_latency valid=%b want=1", bus.o_data_valid);
    end
    bus.i_req = 4'b0000;
    e = sb.pop_front();
    o = observe();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL single_payload got=%h want=%h", o, e);
    end
    @(negedge clk);
    total++;
    if (bus.o_data_valid !== 1'b0 || bus.o_grant !== 4'b0000) begin
      bad++;
      $display("FAIL single_clear valid=%b grant=%b want=0/0000", bus.o_data_valid, bus.o_grant);
    end
    wait_idle("single");
  endtask

  task automatic test_fairness();
    exp_t e, o;
    bit ok;
    int prev_cyc;
    logic [W-1:0] prev_ts;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    m_rr = 2'd0;
    m_id = 32'h03BA;
    bus.i_req = 4'b1111;
    prev_cyc = 0;
    prev_ts  = '0;
    for (int k = 0; k < 5; k++) begin
      push_exp(4'b1111);
      wait_valid(ok);
      e = sb.pop_front();
      o = observe();
      total++;
      if (!ok || o !== e) begin
        bad++;
        $display("FAIL fair_issue%0d valid=%b got=%h want=%h", k, ok, o, e);
      end
      if (k > 0) begin
        total++;
        if (cyc - prev_cyc !== 4) begin
          bad++;
          $display("FAIL fair_period%0d got=%0d want=4", k, cyc - prev_cyc);
        end
        total++;
        if (bus.o_timestamp - prev_ts !== 32'd4) begin
          bad++;
          $display("FAIL fair_ts%0d got=%0d want=4", k, bus.o_timestamp - prev_ts);
        end
      end
      prev_cyc = cyc;
      prev_ts  = bus.o_timestamp;
    end
    bus.i_req = 4'b0000;
    wait_idle("fair");
  endtask

  task automatic test_gating(input bit use_enable);
    exp_t e, o;
    bit seen;
    @(negedge clk);
    bus.i_req = 4'b0001;
    if (use_enable) bus.i_enable = 1'b0;
    else            bus.i_book_is_busy = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_data_valid !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL gate_hold%0d valid seen=1 want=0", use_enable);
    end
    bus.i_enable       = 1'b1;
    bus.i_book_is_busy = 1'b0;
    push_exp(4'b0001);
    @(negedge clk);
    e = sb.pop_front();
    o = observe();
    total++;
    if (bus.o_data_valid !== 1'b1 || o !== e) begin
      bad++;
      $display("FAIL gate_release%0d valid=%b got=%h want=%h", use_enable, bus.o_data_valid, o, e);
    end
    bus.i_req = 4'b0000;
    wait_idle("gate");
  endtask

  task automatic test_wrap();
    logic [W-1:0] ids[2];
    logic [W-1:0] tss[2];
    bit ok;
    @(negedge clk);
    bus_w.i_req = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus_w.o_data_valid === 1'b1) begin
          ok = 1;
          break;
        end
      end
      ids[k] = bus_w.o_order_id;
      tss[k] = bus_w.o_timestamp;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL wrap_timeout%0d valid never seen", k);
      end
    end
    bus_w.i_req = 4'b0000;
    total++;
    if (ids[0] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_id0 got=%h want=ffffffff", ids[0]);
    end
    total++;
    if (ids[1] !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_id1 got=%h want=00000000", ids[1]);
    end
    total++;
    if (tss[1] - tss[0] !== 32'd4) begin
      bad++;
      $display("FAIL wrap_ts_delta got=%0d want=4", tss[1] - tss[0]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    bit ok;
    @(negedge clk);
    bus.i_req = 4'b0010;
    push_exp(4'b0010);
    wait_valid(ok);
    void'(sb.pop_front());
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_issue valid never seen");
    end
    rst = 1'b1;
    bus.i_req = 4'b1111;
    @(negedge clk);
    total++;
    if (bus.o_data_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_clear valid=%b busy=%b grant=%b want=0/0/0000",
               bus.o_data_valid, bus.o_busy, bus.o_grant);
    end
    rst  = 1'b0;
    m_rr = 2'd0;
    m_id = 32'h03BA;
    push_exp(4'b1111);
    wait_valid(ok);
    bus.i_req = 4'b0000;
    e = sb.pop_front();
    o = observe();
    total++;
    if (!ok || o !== e) begin
      bad++;
      $display("FAIL midrst_first valid=%b got=%h want=%h", ok, o, e);
    end
    wait_idle("midrst");
  endtask

  initial begin
    rst                  = 1'b1;
    bus.i_enable         = 1'b1;
    bus.i_book_is_busy   = 1'b0;
    bus.i_req            = 4'b0000;
    bus.i_req_trade_type = 4'b0000;
    bus.i_req_buy_price  = '0;
    bus.i_req_sell_price = '0;
    bus.i_req_quantity   = '0;
    bus_w.i_enable         = 1'b1;
    bus_w.i_book_is_busy   = 1'b0;
    bus_w.i_req            = 4'b0000;
    bus_w.i_req_trade_type = 4'b0000;
    bus_w.i_req_buy_price  = '0;
    bus_w.i_req_sell_price = '0;
    bus_w.i_req_quantity   = '0;
    m_rr = 2'd0;
    m_id = 32'h03BA;
    for (int n = 0; n < 4; n++)
      set_lane(n, n[0], 32'h100 + n, 32'h200 + n, 16'(16'h10 + n));

    test_reset();
    test_single();
    test_fairness();
    test_gating(1'b0);
    test_gating(1'b1);
    test_wrap();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
